adc_ddr_capture: RTL and testbench

Single-clock front end for a dual-channel, DDR-multiplexed ADC such as the AD9643. On each ADC clock cycle it captures the rising-edge and falling-edge data words, plus the DDR over-range flag. It emits each channel as a 16-bit zero-extended AXI-Stream-like word with its own valid, suppressing words flagged over-range. It sits between the ADC LVDS/CMOS pins and the downstream sample FIFOs/DMA.

---
 rtl/adc_ddr_capture_pkg.sv | 14 +
 rtl/ddr_in_cell.sv | 35 +++
 rtl/adc_ddr_capture.sv | 112 +++++++++++
 tb/tb_adc_ddr_capture.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ddr_capture_pkg.sv
// adc_ddr_capture_pkg: shared constants and parameter range checks for the DDR ADC front end.
package adc_ddr_capture_pkg;

    localparam int OUT_W = 16;

    function automatic bit width_ok(input int w);
        return (w >= 1) && (w <= OUT_W);
    endfunction

    function automatic bit sync_ok(input int n);
        return (n >= 2) && (n <= 10);
    endfunction

endpackage

// File: rtl/ddr_in_cell.sv
// ddr_in_cell: behavioural DDR input cell; rising word on q1_o, falling word on q2_o, both rising-aligned.
module ddr_in_cell #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         ce_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q1_o,
    output logic [W-1:0] q2_o
);

    logic [W-1:0] rise_q, fall_q, q1_q, q2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_q <= '0;
            q1_q   <= '0;
            q2_q   <= '0;
        end else if (ce_i) begin
            q1_q   <= rise_q;
            q2_q   <= fall_q;
            rise_q <= d_i;
        end
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fall_q <= '0;
        else if (ce_i) fall_q <= d_i;
    end

    assign q1_o = q1_q;
    assign q2_o = q2_q;

endmodule

// File: rtl/adc_ddr_capture.sv
// adc_ddr_capture: dual-channel DDR ADC capture into zero-extended per-channel streams,
// dropping over-range words and words offered while the sink is not ready.
module adc_ddr_capture
    import adc_ddr_capture_pkg::*;
#(
    parameter int DATA_WIDTH  = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic [DATA_WIDTH-1:0] adc_din,
    input  logic                  adc_or_in,
    input  logic                  ddr_data_en,
    input  logic                  m_axi_tready,
    output logic                  m_axi_tvalid_chA,
    output logic [OUT_W-1:0]      m_axi_tdata_chA,
    output logic                  m_axi_tvalid_chB,
    output logic [OUT_W-1:0]      m_axi_tdata_chB,
    output logic [1:0]            adc_or_state,
    output logic                  adc_data_rdy,
    output logic                  m_axis_aclk
);

    if (!width_ok(DATA_WIDTH)) begin : g_bad_width
        $error("adc_ddr_capture: DATA_WIDTH must be 1..16");
    end
    if (!sync_ok(SYNC_STAGES)) begin : g_bad_sync
        $error("adc_ddr_capture: SYNC_STAGES must be 2..10");
    end

    logic                        en_s, or_a, or_b, take_a, take_b;
    logic [DATA_WIDTH-1:0]       q1, q2;
    logic [SYNC_STAGES-1:0]      en_sync_q, en_sync_d;
    logic [SYNC_STAGES-1:0][1:0] or_sync_q, or_sync_d;
    logic [1:0]                  valid_q, valid_d, rdy_a_q, rdy_a_d;
    logic                        rdy_b_q, rdy_b_d;
    logic                        tvalid_a_q, tvalid_a_d, tvalid_b_q, tvalid_b_d;
    logic [OUT_W-1:0]            tdata_a_q, tdata_a_d, tdata_b_q, tdata_b_d;

    assign en_s = en_sync_q[SYNC_STAGES-1];

    // Data bits freeze with the enable; the over-range bit always runs so the flag tracks the pins.
    for (genvar i = 0; i <= DATA_WIDTH; i++) begin : g_cell
        if (i < DATA_WIDTH) begin : g_data
            ddr_in_cell #(.W(1)) u_cell (
                .clk_i  (m_axi_aclk),
                .rst_ni (m_axi_aresetn),
                .ce_i   (en_s),
                .d_i    (adc_din[i]),
                .q1_o   (q1[i]),
                .q2_o   (q2[i])
            );
        end else begin : g_or
            ddr_in_cell #(.W(1)) u_cell (
                .clk_i  (m_axi_aclk),
                .rst_ni (m_axi_aresetn),
                .ce_i   (1'b1),
                .d_i    (adc_or_in),
                .q1_o   (or_b),
                .q2_o   (or_a)
            );
        end
    end

    // or_a is flagged on the falling edge, so channel A is masked one cycle later than B.
    always_comb begin
        en_sync_d  = {en_sync_q[SYNC_STAGES-2:0], ddr_data_en};
        or_sync_d  = {or_sync_q[SYNC_STAGES-2:0], {or_a, or_b}};
        valid_d    = {en_s, valid_q[1]};
        rdy_a_d    = {or_a, rdy_a_q[1]};
        rdy_b_d    = or_b;
        take_a     = m_axi_tready & en_s & ~rdy_a_q[1];
        take_b     = m_axi_tready & en_s & ~or_b;
        tvalid_a_d = take_a & valid_q[0];
        tvalid_b_d = take_b & valid_q[1];
        tdata_a_d  = take_a ? OUT_W'(q1) : tdata_a_q;
        tdata_b_d  = take_b ? OUT_W'(q2) : tdata_b_q;
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            en_sync_q  <= '0;
            or_sync_q  <= '0;
            valid_q    <= '0;
            rdy_a_q    <= '0;
            rdy_b_q    <= 1'b0;
            tvalid_a_q <= 1'b0;
            tvalid_b_q <= 1'b0;
            tdata_a_q  <= '0;
            tdata_b_q  <= '0;
        end else begin
            en_sync_q  <= en_sync_d;
            or_sync_q  <= or_sync_d;
            valid_q    <= valid_d;
            rdy_a_q    <= rdy_a_d;
            rdy_b_q    <= rdy_b_d;
            tvalid_a_q <= tvalid_a_d;
            tvalid_b_q <= tvalid_b_d;
            tdata_a_q  <= tdata_a_d;
            tdata_b_q  <= tdata_b_d;
        end
    end

    assign m_axi_tvalid_chA = tvalid_a_q;
    assign m_axi_tdata_chA  = tdata_a_q;
    assign m_axi_tvalid_chB = tvalid_b_q;
    assign m_axi_tdata_chB  = tdata_b_q;
    assign adc_or_state     = or_sync_q[SYNC_STAGES-1];
    assign adc_data_rdy     = ~(rdy_a_q[0] | rdy_b_q);
    assign m_axis_aclk      = m_axi_aclk;

endmodule

// File: tb/tb_adc_ddr_capture.sv
// tb_adc_ddr_capture: directed checks of capture alignment, enable latency, over-range masking,
// dropped words under backpressure and asynchronous reset.
module tb_adc_ddr_capture;

    logic        clk;
    logic        rst_n;
    logic [13:0] din;
    logic        or_in;
    logic        en;
    logic        tready;
    logic        va, vb, rdy, aclk_o;
    logic [15:0] da, db;
    logic [1:0]  ors;
    int          total = 0;
    int          bad = 0;

    adc_ddr_capture #(.DATA_WIDTH(14), .SYNC_STAGES(2)) dut (
        .m_axi_aclk       (clk),
        .m_axi_aresetn    (rst_n),
        .adc_din          (din),
        .adc_or_in        (or_in),
        .ddr_data_en      (en),
        .m_axi_tready     (tready),
        .m_axi_tvalid_chA (va),
        .m_axi_tdata_chA  (da),
        .m_axi_tvalid_chB (vb),
        .m_axi_tdata_chB  (db),
        .adc_or_state     (ors),
        .adc_data_rdy     (rdy),
        .m_axis_aclk      (aclk_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One ADC cycle: rise word/or before the rising edge, fall word/or before the falling edge.
    task automatic cyc(input logic [13:0] r, input logic [13:0] f,
                       input logic orr = 1'b0, input logic orf = 1'b0);
        din = r;
        or_in = orr;
        @(posedge clk);
        #1;
        din = f;
        or_in = orf;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        tready = 1'b1;
        din = '0;
        or_in = 1'b0;
        #1;
        chk("rst_va", {15'd0, va}, 16'd0);
        chk("rst_vb", {15'd0, vb}, 16'd0);
        chk("rst_da", da, 16'h0000);
        chk("rst_db", db, 16'h0000);
        chk("rst_ors", {14'd0, ors}, 16'd0);
        chk("rst_rdy", {15'd0, rdy}, 16'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("aclk_copy", {15'd0, aclk_o}, {15'd0, clk});
        cyc(14'h1111, 14'h0222);
        chk("idle_vb", {15'd0, vb}, 16'd0);

        // enable latency: en_s rises after the 2nd edge
        en = 1'b1;
        cyc(14'h1111, 14'h0222);
        chk("en1_vb", {15'd0, vb}, 16'd0);
        cyc(14'h1111, 14'h0222);
        cyc(14'h1111, 14'h0222);
        chk("en3_vb", {15'd0, vb}, 16'd0);
        cyc(14'h1111, 14'h0222);
        chk("en4_vb", {15'd0, vb}, 16'd1);
        chk("en4_va", {15'd0, va}, 16'd0);
        chk("en4_db", db, 16'h0222);
        cyc(14'h1111, 14'h0222);
        chk("en5_va", {15'd0, va}, 16'd1);
        chk("en5_da", da, 16'h1111);

        // basic capture, two-edge latency
        cyc(14'h1234, 14'h0ABC);
        cyc(14'h2001, 14'h3FFF);
        cyc(14'h0555, 14'h0AAA);
        chk("cap_da", da, 16'h1234);
        chk("cap_db", db, 16'h0ABC);
        chk("cap_va", {15'd0, va}, 16'd1);
        chk("cap_vb", {15'd0, vb}, 16'd1);
        cyc(14'h0101, 14'h0201);
        chk("cap2_da", da, 16'h2001);
        chk("cap2_db", db, 16'h3FFF);

        // over-range on channel B (rising phase)
        cyc(14'h0102, 14'h0202, 1'b1, 1'b0);
        chk("orb1_da", da, 16'h0555);
        chk("orb1_db", db, 16'h0AAA);
        cyc(14'h0103, 14'h0203, 1'b1, 1'b0);
        chk("orb2_db", db, 16'h0201);
        chk("orb2_vb", {15'd0, vb}, 16'd1);
        chk("orb2_rdy", {15'd0, rdy}, 16'd1);
        cyc(14'h0104, 14'h0204, 1'b1, 1'b0);
        chk("orb3_vb", {15'd0, vb}, 16'd0);
        chk("orb3_db", db, 16'h0201);
        chk("orb3_da", da, 16'h0102);
        chk("orb3_va", {15'd0, va}, 16'd1);
        chk("orb3_rdy", {15'd0, rdy}, 16'd0);
        cyc(14'h0105, 14'h0205);
        chk("orb4_ors", {14'd0, ors}, 16'd1);
        chk("orb4_vb", {15'd0, vb}, 16'd0);
        cyc(14'h0106, 14'h0206);
        chk("orb5_db", db, 16'h0201);
        chk("orb5_da", da, 16'h0104);
        chk("orb5_rdy", {15'd0, rdy}, 16'd0);
        cyc(14'h0107, 14'h0207);
        chk("orb6_vb", {15'd0, vb}, 16'd1);
        chk("orb6_db", db, 16'h0205);
        chk("orb6_rdy", {15'd0, rdy}, 16'd1);
        cyc(14'h0108, 14'h0208);

        // over-range on channel A (falling phase)
        cyc(14'h0301, 14'h0401);
        cyc(14'h0302, 14'h0402, 1'b0, 1'b1);
        cyc(14'h0303, 14'h0403, 1'b0, 1'b1);
        cyc(14'h0304, 14'h0404, 1'b0, 1'b1);
        chk("ora3_da", da, 16'h0302);
        chk("ora3_va", {15'd0, va}, 16'd1);
        chk("ora3_rdy", {15'd0, rdy}, 16'd1);
        cyc(14'h0305, 14'h0405);
        chk("ora4_va", {15'd0, va}, 16'd0);
        chk("ora4_da", da, 16'h0302);
        chk("ora4_rdy", {15'd0, rdy}, 16'd0);
        chk("ora4_ors", {14'd0, ors}, 16'd2);
        chk("ora4_vb", {15'd0, vb}, 16'd1);
        chk("ora4_db", db, 16'h0403);
        cyc(14'h0306, 14'h0406);
        cyc(14'h0307, 14'h0407);
        chk("ora6_va", {15'd0, va}, 16'd0);
        chk("ora6_da", da, 16'h0302);
        cyc(14'h0308, 14'h0408);
        chk("ora7_va", {15'd0, va}, 16'd1);
        chk("ora7_da", da, 16'h0306);
        chk("ora7_rdy", {15'd0, rdy}, 16'd1);
        chk("ora7_ors", {14'd0, ors}, 16'd0);

        // backpressure drops words
        cyc(14'h0500, 14'h0600);
        tready = 1'b0;
        cyc(14'h0501, 14'h0601);
        cyc(14'h0502, 14'h0602);
        chk("bp2_va", {15'd0, va}, 16'd0);
        chk("bp2_vb", {15'd0, vb}, 16'd0);
        chk("bp2_da", da, 16'h0307);
        chk("bp2_db", db, 16'h0407);
        cyc(14'h0503, 14'h0603);
        cyc(14'h0504, 14'h0604);
        chk("bp4_va", {15'd0, va}, 16'd0);
        chk("bp4_da", da, 16'h0307);
        chk("bp4_db", db, 16'h0407);
        tready = 1'b1;
        cyc(14'h0505, 14'h0605);
        chk("bp5_da", da, 16'h0503);
        chk("bp5_db", db, 16'h0603);
        chk("bp5_va", {15'd0, va}, 16'd1);
        chk("bp5_vb", {15'd0, vb}, 16'd1);

        // enable drop
        cyc(14'h0700, 14'h0800);
        en = 1'b0;
        cyc(14'h0700, 14'h0800);
        cyc(14'h0700, 14'h0800);
        chk("drop2_va", {15'd0, va}, 16'd1);
        chk("drop2_vb", {15'd0, vb}, 16'd1);
        chk("drop2_da", da, 16'h0700);
        chk("drop2_db", db, 16'h0800);
        cyc(14'h0700, 14'h0800);
        chk("drop3_va", {15'd0, va}, 16'd0);
        chk("drop3_vb", {15'd0, vb}, 16'd0);
        chk("drop3_da", da, 16'h0700);

        // asynchronous reset between edges
        en = 1'b1;
        cyc(14'h0700, 14'h0800);
        cyc(14'h0700, 14'h0800);
        cyc(14'h0700, 14'h0800);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_va", {15'd0, va}, 16'd0);
        chk("arst_vb", {15'd0, vb}, 16'd0);
        chk("arst_da", da, 16'h0000);
        chk("arst_db", db, 16'h0000);
        chk("arst_rdy", {15'd0, rdy}, 16'd1);
        chk("arst_ors", {14'd0, ors}, 16'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc(14'h1111, 14'h0222);
        cyc(14'h1111, 14'h0222);
        cyc(14'h1111, 14'h0222);
        chk("rel3_vb", {15'd0, vb}, 16'd0);
        cyc(14'h1111, 14'h0222);
        chk("rel4_vb", {15'd0, vb}, 16'd1);
        chk("rel4_va", {15'd0, va}, 16'd0);
        chk("rel4_db", db, 16'h0222);
        cyc(14'h1111, 14'h0222);
        chk("rel5_va", {15'd0, va}, 16'd1);
        chk("rel5_da", da, 16'h1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
